// File: rtl/mc_sched_queue.sv
// mc_sched_queue: holds pending memory requests, scores each one from its
// attribute class and age, and presents the best candidate on a registered
// valid/ready grant port.
module mc_sched_queue #(
   parameter int DEPTH     = 16,
   parameter int AGE_W     = 6,
   parameter int SCORE_W   = 8,
   parameter int W_HI      = 128,
   parameter int W_MID     = 8,
   parameter int W_LO      = 2,
   parameter int W_B0      = 4,
   parameter int STARVE_EN = 0
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       alloc_valid_i,
   input  logic [2:0]                 alloc_attr_i,
   output logic                       alloc_ready_o,
   output logic [$clog2(DEPTH)-1:0]   alloc_idx_o,
   input  logic                       upd_valid_i,
   input  logic [$clog2(DEPTH)-1:0]   upd_idx_i,
   input  logic [2:0]                 upd_attr_i,
   output logic                       grant_valid_o,
   input  logic                       grant_ready_i,
   output logic [$clog2(DEPTH)-1:0]   grant_idx_o,
   output logic [SCORE_W-1:0]         grant_score_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int IDX_W  = $clog2(DEPTH);
   localparam int CALC_W = SCORE_W + 2;
   localparam logic [AGE_W-1:0]   AGE_MAX   = '1;
   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
   localparam logic [CALC_W-1:0]  SAT_LIM   = CALC_W'(SCORE_MAX);

   logic [DEPTH-1:0]   valid_q, valid_d;
   logic [2:0]         attr_q [DEPTH];
   logic [2:0]         attr_d [DEPTH];
   logic [AGE_W-1:0]   age_q  [DEPTH];
   logic [AGE_W-1:0]   age_d  [DEPTH];
   logic               grant_valid_q, grant_valid_d;
   logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
   logic [SCORE_W-1:0] grant_score_q, grant_score_d;
   logic [IDX_W:0]     count_q, count_d;

   logic [CALC_W-1:0]  raw   [DEPTH];
   logic [SCORE_W-1:0] score [DEPTH];
   logic [DEPTH-1:0]   held_vec, eligible;
   logic               free_any;
   logic [IDX_W-1:0]   free_idx;
   logic               sel_found;
   logic [IDX_W-1:0]   sel_idx;
   logic [SCORE_W-1:0] sel_score;
   logic               alloc_fire, hs_fire, grant_load;

   function automatic logic [CALC_W-1:0] class_w(input logic [1:0] cls);
      case (cls)
         2'b11:   class_w = CALC_W'(W_HI);
         2'b10:   class_w = CALC_W'(W_MID);
         2'b01:   class_w = CALC_W'(W_LO);
         default: class_w = '0;
      endcase
   endfunction

   // Per-entry score: class weight + bit-0 bonus + age, saturated; optional starvation override.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         raw[i]   = class_w(attr_q[i][2:1])
                  + (attr_q[i][0] ? CALC_W'(W_B0) : '0)
                  + CALC_W'(age_q[i]);
         score[i] = (raw[i] > SAT_LIM) ? SCORE_MAX : raw[i][SCORE_W-1:0];
         if ((STARVE_EN != 0) && (age_q[i] == AGE_MAX)) score[i] = SCORE_MAX;
         if (!valid_q[i]) score[i] = '0;
      end
   end

   // Lowest free slot and max-score selection; the held entry is excluded so a
   // handshake edge can load the next winner immediately.
   always_comb begin
      free_any  = ~&valid_q;
      free_idx  = '0;
      sel_found = 1'b0;
      sel_idx   = '0;
      sel_score = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!valid_q[i]) free_idx = IDX_W'(i);
      end
      for (int i = 0; i < DEPTH; i++) begin
         held_vec[i] = grant_valid_q && (grant_idx_q == IDX_W'(i));
      end
      eligible = valid_q & ~held_vec;
      for (int i = 0; i < DEPTH; i++) begin
         // strict > keeps the lowest index on ties
         if (eligible[i] && (!sel_found || (score[i] > sel_score))) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(i);
            sel_score = score[i];
         end
      end
   end

   // Next-state for entries, grant register and occupancy count.
   always_comb begin
      alloc_fire    = alloc_valid_i && free_any;
      hs_fire       = grant_valid_q && grant_ready_i;
      grant_load    = !grant_valid_q || grant_ready_i;
      valid_d       = valid_q;
      attr_d        = attr_q;
      age_d         = age_q;
      grant_valid_d = grant_valid_q;
      grant_idx_d   = grant_idx_q;
      grant_score_d = grant_score_q;
      count_d       = count_q;

      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && !held_vec[i] && (age_q[i] != AGE_MAX)) age_d[i] = age_q[i] + 1'b1;
      end
      if (upd_valid_i && valid_q[upd_idx_i]) attr_d[upd_idx_i] = upd_attr_i;
      if (alloc_fire) begin
         valid_d[free_idx] = 1'b1;
         attr_d[free_idx]  = alloc_attr_i;
         age_d[free_idx]   = '0;
      end
      if (hs_fire) valid_d[grant_idx_q] = 1'b0;

      if (grant_load) begin
         grant_valid_d = sel_found;
         grant_idx_d   = sel_idx;
         grant_score_d = sel_score;
      end

      case ({alloc_fire, hs_fire})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // State registers with synchronous reset that overrides all same-cycle activity.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q       <= '0;
         attr_q        <= '{default: '0};
         age_q         <= '{default: '0};
         grant_valid_q <= 1'b0;
         grant_idx_q   <= '0;
         grant_score_q <= '0;
         count_q       <= '0;
      end else begin
         valid_q       <= valid_d;
         attr_q        <= attr_d;
         age_q         <= age_d;
         grant_valid_q <= grant_valid_d;
         grant_idx_q   <= grant_idx_d;
         grant_score_q <= grant_score_d;
         count_q       <= count_d;
      end
   end

   assign alloc_ready_o = free_any;
   assign alloc_idx_o   = free_idx;
   assign grant_valid_o = grant_valid_q;
   assign grant_idx_o   = grant_idx_q;
   assign grant_score_o = grant_score_q;
   assign count_o       = count_q;

endmodule
